// File: rtl/viterbi_frame_ctrl_if.sv
// Handshake bundle between the frame sequencer and its neighbours:
// request side, deinterleaver input, decoder port and descrambler output.
interface viterbi_frame_ctrl_if #(
  parameter int LEN_W = 9
);
  logic             req_valid;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             dec_Start;
  logic             dec_x;
  logic [LEN_W-1:0] dec_Length;
  logic             dec_Out;
  logic             dec_Valid;
  logic             out_bit;
  logic             out_valid;
  logic             out_last;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output req_valid, req_len, in_bit, in_valid, dec_Out, dec_Valid,
    input  req_ready, in_ready, dec_Start, dec_x, dec_Length,
           out_bit, out_valid, out_last, done, err, busy
  );

  modport slave (
    input  req_valid, req_len, in_bit, in_valid, dec_Out, dec_Valid,
    output req_ready, in_ready, dec_Start, dec_x, dec_Length,
           out_bit, out_valid, out_last, done, err, busy
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the 64-state Viterbi decoder: buffers 2*len coded bits,
// streams them gap-free under Start, then forwards len decoded bits.
// Optional WAIT watchdog enabled by defining VITERBI_CTRL_TIMEOUT_EN.
module viterbi_frame_ctrl #(
  parameter int FRAME   = 512,
  parameter int LEN_W   = 9,
  parameter int TIMEOUT = 4096
) (
  input  logic                 Clk,
  input  logic                 Reset,
  viterbi_frame_ctrl_if.slave  bus
);

  localparam int CNT_W = LEN_W + 1;
  localparam int AW    = $clog2(2 * FRAME);
  localparam logic [CNT_W-1:0] FRAME_L = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CONE_L  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LONE_L  = {{(LEN_W-1){1'b0}}, 1'b1};

  if (FRAME > (1 << LEN_W) || TIMEOUT < 1) begin : g_bad_cfg
    $error("viterbi_frame_ctrl: FRAME must fit LEN_W and TIMEOUT must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_CLEAR = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [LEN_W-1:0] ocnt_q, ocnt_d;
  logic             dec_x_q, dec_x_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             req_ready_q, in_ready_q, busy_q, dec_start_q;
  logic             buf_we_s;
  logic [CNT_W-1:0] last_idx_s;
  logic [CNT_W-1:0] rnext_s;
  logic             buf_q [0:2*FRAME-1];

`ifdef VITERBI_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST_L = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign last_idx_s = {len_q, 1'b0} - CONE_L;
  assign rnext_s    = rcnt_q + CONE_L;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    ocnt_d      = ocnt_q;
    dec_x_d     = 1'b0;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    buf_we_s    = 1'b0;
`ifdef VITERBI_CTRL_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          len_d = bus.req_len;
          if (bus.req_len == {LEN_W{1'b0}} || {1'b0, bus.req_len} >= FRAME_L) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            wcnt_d  = {CNT_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          buf_we_s = 1'b1;
          wcnt_d   = wcnt_q + CONE_L;
          if (wcnt_q == last_idx_s) begin
            // Bit 0 is already stored, so it can be on dec_x in the first Start cycle.
            state_d = S_RUN;
            rcnt_d  = {CNT_W{1'b0}};
            dec_x_d = buf_q[0];
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (rcnt_q == last_idx_s) begin
          state_d = S_WAIT;
`ifdef VITERBI_CTRL_TIMEOUT_EN
          tmo_d   = {TMO_W{1'b0}};
`endif
        end else begin
          rcnt_d  = rnext_s;
          dec_x_d = buf_q[rnext_s[AW-1:0]];
        end
      end
      S_WAIT: begin
        // The cycle that shows dec_Valid already carries decoded bit 0.
        if (bus.dec_Valid) begin
          state_d     = S_DRAIN;
          out_bit_d   = bus.dec_Out;
          out_valid_d = 1'b1;
          out_last_d  = (len_q == LONE_L);
          ocnt_d      = LONE_L;
        end else begin
`ifdef VITERBI_CTRL_TIMEOUT_EN
          if (tmo_q == TMO_LAST_L) begin
            err_d   = 1'b1;
            state_d = S_CLEAR;
          end else begin
            tmo_d   = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_DRAIN: begin
        if (ocnt_q == len_q) begin
          done_d  = 1'b1;
          state_d = S_CLEAR;
        end else begin
          out_bit_d   = bus.dec_Out;
          out_valid_d = 1'b1;
          out_last_d  = (ocnt_q == len_q - LONE_L);
          ocnt_d      = ocnt_q + LONE_L;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      len_q       <= {LEN_W{1'b0}};
      wcnt_q      <= {CNT_W{1'b0}};
      rcnt_q      <= {CNT_W{1'b0}};
      ocnt_q      <= {LEN_W{1'b0}};
      dec_x_q     <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      dec_start_q <= 1'b0;
`ifdef VITERBI_CTRL_TIMEOUT_EN
      tmo_q       <= {TMO_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      ocnt_q      <= ocnt_d;
      dec_x_q     <= dec_x_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_ready_q <= (state_d == S_IDLE);
      in_ready_q  <= (state_d == S_LOAD);
      busy_q      <= (state_d != S_IDLE);
      dec_start_q <= (state_d == S_RUN) || (state_d == S_WAIT) || (state_d == S_DRAIN);
`ifdef VITERBI_CTRL_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Coded-bit buffer; contents need no reset.
  always_ff @(posedge Clk) begin
    if (buf_we_s) begin
      buf_q[wcnt_q[AW-1:0]] <= bus.in_bit;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.dec_Start  = dec_start_q;
  assign bus.dec_x      = dec_x_q;
  assign bus.dec_Length = len_q;
  assign bus.out_bit    = out_bit_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl: a table of frame vectors run through
// a K=7 (133,171) encoder model and a decoder stub, plus reset/timeout corners.
module tb_viterbi_frame_ctrl;
  localparam int FRAME = 512;
  localparam int LEN_W = 10;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic coded [0:2*FRAME-1];

  viterbi_frame_ctrl_if #(.LEN_W(LEN_W)) vif ();

  viterbi_frame_ctrl #(.FRAME(FRAME), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (vif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [511:0]     data;
    bit               toggle;
    int               nflip;
    int               abort_at;
    int               wait_cyc;
    bit               no_valid;
    bit               exp_reject;
  } frame_vec_t;

  frame_vec_t vecs[$];

  function automatic frame_vec_t mk(input int len, input logic [511:0] data, input bit toggle,
                                    input int nflip, input int abort_at, input int wait_cyc,
                                    input bit no_valid, input bit exp_reject);
    frame_vec_t v;
    v.len = LEN_W'(len); v.data = data; v.toggle = toggle; v.nflip = nflip;
    v.abort_at = abort_at; v.wait_cyc = wait_cyc; v.no_valid = no_valid;
    v.exp_reject = exp_reject;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every output at its reset value: req_ready=1, everything else 0.
  task automatic check_idle(input string name);
    check(name, {vif.req_ready, vif.in_ready, vif.dec_Start, vif.dec_x, vif.dec_Length,
                 vif.out_bit, vif.out_valid, vif.out_last, vif.done, vif.err, vif.busy},
          {1'b1, 3'b000, {LEN_W{1'b0}}, 6'b000000});
  endtask

  task automatic encode(input frame_vec_t v);
    logic [6:0] sr = 7'd0;
    for (int k = 0; k < int'(v.len); k++) begin
      sr = {sr[5:0], v.data[k]};
      coded[2*k]   = ^(sr & 7'o133);
      coded[2*k+1] = ^(sr & 7'o171);
    end
    for (int f = 0; f < v.nflip; f++) coded[f*97+5] = ~coded[f*97+5];
  endtask

  task automatic run_frame(input frame_vec_t v, input int idx);
    int len = int'(v.len);
    int i, cyc, errs;
    string tag = $sformatf("v%0d", idx);
    cyc = 0;
    while (vif.req_ready !== 1'b1 && cyc < 8) begin step(); cyc++; end
    check({tag, "_req_ready"}, vif.req_ready, 1'b1);
    vif.req_valid = 1'b1; vif.req_len = v.len;
    step();
    vif.req_valid = 1'b0;
    if (v.exp_reject) begin
      check({tag, "_reject"}, {vif.err, vif.req_ready, vif.in_ready, vif.busy, vif.dec_Start}, 5'b11000);
      step();
      check({tag, "_reject_after"}, {vif.err, vif.req_ready, vif.in_ready, vif.dec_Start}, 4'b0100);
      return;
    end
    check({tag, "_accept"}, {vif.req_ready, vif.in_ready, vif.busy, vif.dec_Length}, {3'b011, v.len});
    encode(v);
    // LOAD: optionally idle every other cycle with a corrupted in_bit.
    i = 0; cyc = 0; errs = 0;
    while (i < 2*len && cyc < 4*len + 8) begin
      if (vif.in_ready !== 1'b1 || vif.dec_Start !== 1'b0) errs++;
      if (v.toggle && cyc % 2 == 1) begin
        vif.in_valid = 1'b0; vif.in_bit = ~coded[i];
      end else begin
        vif.in_valid = 1'b1; vif.in_bit = coded[i]; i++;
      end
      step(); cyc++;
    end
    vif.in_valid = 1'b0; vif.in_bit = 1'b0;
    check({tag, "_load"}, errs, 0);
    errs = 0;
    for (int k = 0; k < 2*len; k++) begin
      if (k == v.abort_at) begin
        rst = 1'b1;
        step();
        check_idle({tag, "_abort"});
        rst = 1'b0;
        return;
      end
      if (vif.dec_Start !== 1'b1 || vif.dec_x !== coded[k] || vif.in_ready !== 1'b0) errs++;
      step();
    end
    check({tag, "_run_stream"}, errs, 0);
    check({tag, "_wait_entry"}, {vif.dec_Start, vif.dec_x, vif.out_valid, vif.busy}, 4'b1001);
    if (v.no_valid) begin
      errs = 0;
      for (int c = 1; c <= TMO; c++) begin
        step();
        if (c < TMO && (vif.err !== 1'b0 || vif.dec_Start !== 1'b1 || vif.out_valid !== 1'b0)) errs++;
      end
      check({tag, "_tmo_quiet"}, errs, 0);
      check({tag, "_tmo_err"}, {vif.err, vif.dec_Start, vif.out_valid, vif.done, vif.busy}, 5'b10001);
      step();
      check({tag, "_tmo_idle"}, {vif.err, vif.req_ready, vif.busy}, 3'b010);
      return;
    end
    errs = 0;
    for (int w = 0; w < v.wait_cyc; w++) begin
      step();
      if (vif.dec_Start !== 1'b1 || vif.out_valid !== 1'b0 || vif.dec_x !== 1'b0) errs++;
    end
    errs = 0;
    for (int k = 0; k < len; k++) begin
      vif.dec_Valid = 1'b1; vif.dec_Out = v.data[k];
      step();
      if (vif.out_valid !== 1'b1 || vif.out_bit !== v.data[k] ||
          vif.out_last !== (k == len-1) || vif.done !== 1'b0 || vif.dec_Start !== 1'b1) errs++;
    end
    vif.dec_Valid = 1'b0; vif.dec_Out = 1'b0;
    check({tag, "_drain"}, errs, 0);
    step();
    check({tag, "_done_clear"}, {vif.done, vif.out_valid, vif.out_last, vif.dec_Start, vif.busy, vif.req_ready}, 6'b100010);
    step();
    check({tag, "_idle_again"}, {vif.done, vif.dec_Start, vif.busy, vif.req_ready}, 4'b0001);
  endtask

  initial begin
    logic [511:0] rnd;
    vif.req_valid = 1'b0; vif.req_len = '0; vif.in_bit = 1'b0; vif.in_valid = 1'b0;
    vif.dec_Out = 1'b0; vif.dec_Valid = 1'b0;
    rnd = '0;
    for (int k = 0; k < 511; k++) rnd[k] = 1'($urandom_range(0, 1));

    //        len  data             tog flip abort wait noV rej
    vecs.push_back(mk(24,  512'hA5C31E,    0, 0,  -1,  3,  0, 0));
    vecs.push_back(mk(24,  512'hA5C31E,    1, 0,  -1,  0,  0, 0));
    vecs.push_back(mk(0,   512'h0,         0, 0,  -1,  0,  0, 1));
    vecs.push_back(mk(512, 512'h0,         0, 0,  -1,  0,  0, 1));
    vecs.push_back(mk(511, rnd,            0, 3,  -1,  5,  0, 0));
    vecs.push_back(mk(24,  512'h3C9F1A,    0, 0,  10,  0,  0, 0));
    vecs.push_back(mk(8,   512'hB4,        0, 0,  -1,  2,  0, 0));
    vecs.push_back(mk(1,   512'h1,         0, 0,  -1,  0,  0, 0));
`ifdef VITERBI_CTRL_TIMEOUT_EN
    vecs.push_back(mk(5,   512'h15,        0, 0,  -1,  0,  1, 0));
`endif

    step(); step();
    check_idle("reset_state");
    rst = 1'b0;
    step();
    check_idle("post_reset_idle");
    foreach (vecs[n]) run_frame(vecs[n], n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
